// File: rtl/cpu6502_bus_ctrl.sv
// 6502 bus controller: decodes core accesses to a wait-stated
// memory port or a req/ack I/O window with timeout.
module cpu6502_bus_ctrl #(
  parameter logic [7:0] IO_PAGE    = 8'hD0,
  parameter int         MEM_WAIT   = 0,
  parameter int         IO_TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] cpu_address,
  input  logic        cpu_write,
  input  logic [7:0]  cpu_data_o,
  output logic [7:0]  cpu_data_i,
  output logic        cpu_ready,
  output logic [15:0] mem_addr,
  output logic        mem_we,
  output logic [7:0]  mem_wdata,
  input  logic [7:0]  mem_rdata,
  output logic        io_req,
  output logic        io_we,
  output logic [7:0]  io_addr,
  output logic [7:0]  io_wdata,
  input  logic [7:0]  io_rdata,
  input  logic        io_ack,
  input  logic        tmo_clr,
  output logic        tmo_flag
);

  typedef enum logic [1:0] {
    IDLE,
    MWAIT,
    IOREQ,
    IODONE
  } state_t;

  localparam bit NO_WAIT = (MEM_WAIT == 0);
  localparam logic [7:0] MW_LOAD =
    NO_WAIT ? 8'd0 : 8'(MEM_WAIT - 1);
  localparam logic [7:0] TMO_LAST =
    8'(IO_TIMEOUT - 1);

  state_t      state;
  logic [7:0]  cnt;
  logic [7:0]  rlatch;
  logic        is_io;
  logic        tmo_hit;

  assign is_io     = (cpu_address[15:8] == IO_PAGE);
  assign mem_addr  = cpu_address;
  assign mem_wdata = cpu_data_o;

  // Timeout fires only when no ack arrives on the last cycle.
  assign tmo_hit = (state == IOREQ) && !io_ack &&
                   (cnt == TMO_LAST);

  // Core-facing handshake and memory strobe.
  always_comb begin
    cpu_ready  = 1'b0;
    mem_we     = 1'b0;
    cpu_data_i = rlatch;
    unique case (state)
      IDLE: begin
        if (!is_io) begin
          cpu_data_i = mem_rdata;
          if (NO_WAIT) begin
            cpu_ready = 1'b1;
            mem_we    = cpu_write;
          end
        end
      end
      MWAIT: begin
        cpu_data_i = mem_rdata;
        if (cnt == 8'd0) begin
          cpu_ready = 1'b1;
          mem_we    = cpu_write;
        end
      end
      IOREQ: begin
        cpu_ready = 1'b0;
      end
      IODONE: begin
        cpu_ready = 1'b1;
      end
      default: begin
        cpu_ready = 1'b0;
      end
    endcase
  end

  // Access sequencing, I/O request registers and timeout flag.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= 8'd0;
      io_req   <= 1'b0;
      io_we    <= 1'b0;
      io_addr  <= 8'd0;
      io_wdata <= 8'd0;
      rlatch   <= 8'd0;
      tmo_flag <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (is_io) begin
            io_req   <= 1'b1;
            io_we    <= cpu_write;
            io_addr  <= cpu_address[7:0];
            io_wdata <= cpu_data_o;
            cnt      <= 8'd0;
            state    <= IOREQ;
          end else if (!NO_WAIT) begin
            cnt   <= MW_LOAD;
            state <= MWAIT;
          end
        end
        MWAIT: begin
          if (cnt == 8'd0) begin
            state <= IDLE;
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        IOREQ: begin
          cnt <= cnt + 8'd1;
          if (io_ack) begin
            if (!io_we) begin
              rlatch <= io_rdata;
            end
            io_req <= 1'b0;
            state  <= IODONE;
          end else if (tmo_hit) begin
            rlatch <= 8'hFF;
            io_req <= 1'b0;
            state  <= IODONE;
          end
        end
        IODONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
      if (tmo_hit) begin
        tmo_flag <= 1'b1;
      end else if (tmo_clr) begin
        tmo_flag <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_cpu6502_bus_ctrl.sv
// Scoreboard bench for cpu6502_bus_ctrl: two instances with
// different wait/timeout settings, random and directed traffic.
module tb_cpu6502_bus_ctrl;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  bit done [2];

  typedef struct {
    int          lat;
    logic [7:0]  data;
    bit          chkd;
    int          nwe;
    logic [7:0]  wd;
    bit          tmo;
    logic [15:0] a;
  } exp_t;

  task automatic chk(input string n, input int act,
                     input int req);
    checks++;
    if (act != req) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h t=%0t",
               n, act, req, $time);
    end
  endtask

  for (genvar g = 0; g < 2; g++) begin : lane
    localparam int MW  = (g == 0) ? 0 : 2;
    localparam int TMO = (g == 0) ? 15 : 3;

    logic        rst_n = 1'b0;
    logic [15:0] addr  = 16'h0;
    logic        we    = 1'b0;
    logic [7:0]  wd    = 8'h0;
    logic [7:0]  mrd   = 8'h0;
    logic        tclr  = 1'b0;
    logic [7:0]  iord  = 8'h0;
    logic        ioack = 1'b0;
    logic [7:0]  data_i;
    logic        ready;
    logic [15:0] maddr;
    logic        mwe;
    logic [7:0]  mwd;
    logic        ioreq;
    logic        iowe;
    logic [7:0]  ioaddr;
    logic [7:0]  iowd;
    logic        tflag;

    exp_t       q[$];
    int         cyc   = 0;
    int         nwe   = 0;
    int         d_cur = 0;
    logic [7:0] rd_cur = 8'h0;
    bit         tmo_m = 1'b0;

    cpu6502_bus_ctrl #(
      .IO_PAGE(8'hD0),
      .MEM_WAIT(MW),
      .IO_TIMEOUT(TMO)
    ) dut (
      .clk(clk),
      .reset_n(rst_n),
      .cpu_address(addr),
      .cpu_write(we),
      .cpu_data_o(wd),
      .cpu_data_i(data_i),
      .cpu_ready(ready),
      .mem_addr(maddr),
      .mem_we(mwe),
      .mem_wdata(mwd),
      .mem_rdata(mrd),
      .io_req(ioreq),
      .io_we(iowe),
      .io_addr(ioaddr),
      .io_wdata(iowd),
      .io_rdata(iord),
      .io_ack(ioack),
      .tmo_clr(tclr),
      .tmo_flag(tflag)
    );

    // Reference: latency, data and flag from the access rules.
    task automatic start(input logic [15:0] a,
                         input logic w,
                         input logic [7:0] wdat,
                         input logic [7:0] m,
                         input int d,
                         input logic [7:0] r,
                         input logic c);
      exp_t e;
      bit to;
      addr = a; we = w; wd = wdat; mrd = m;
      tclr = c; d_cur = d; rd_cur = r;
      to = 1'b0;
      e.a = a; e.wd = wdat; e.nwe = 0;
      if (a[15:8] == 8'hD0) begin
        if (d <= TMO) begin
          e.lat = d + 2; e.data = r; e.chkd = !w;
        end else begin
          e.lat = TMO + 2; e.data = 8'hFF;
          e.chkd = 1'b1; to = 1'b1;
        end
      end else begin
        e.lat = MW + 1; e.data = m; e.chkd = 1'b1;
        e.nwe = w ? 1 : 0;
      end
      if (to) e.tmo = 1'b1;
      else if (c && e.lat > 1) e.tmo = 1'b0;
      else e.tmo = tmo_m;
      if (c) tmo_m = 1'b0;
      else if (to) tmo_m = 1'b1;
      q.push_back(e);
    endtask

    task automatic wait_done();
      int n = 0;
      do begin
        @(posedge clk);
        n++;
      end while (q.size() > 0 && n < 100);
      if (q.size() > 0) begin
        chk($sformatf("L%0d_done_bound", g), n, 0);
        q.delete();
      end
      #1;
    endtask

    task automatic run(input logic [15:0] a,
                       input logic w,
                       input logic [7:0] wdat,
                       input logic [7:0] m,
                       input int d,
                       input logic [7:0] r,
                       input logic c);
      start(a, w, wdat, m, d, r, c);
      wait_done();
    endtask

    task automatic rnd_txn();
      logic [15:0] a;
      int sel;
      sel = int'($urandom % 8);
      a = 16'($urandom);
      if (sel < 4) a[15:8] = 8'hD0;
      else if (sel == 4) a = ($urandom % 2) ? 16'hCFFF
                                            : 16'hD100;
      else if (a[15:8] == 8'hD0) a[15:8] = 8'hD1;
      run(a, 1'($urandom), 8'($urandom), 8'($urandom),
          int'($urandom_range(1, TMO + 2)),
          8'($urandom), ($urandom % 4) == 0);
    endtask

    // Monitor: pops one expectation per completed access.
    initial begin
      exp_t e;
      forever begin
        @(negedge clk);
        if (!rst_n) begin
          cyc = 0; nwe = 0;
        end else if (q.size() > 0) begin
          cyc++;
          if (mwe) begin
            nwe++;
            chk($sformatf("L%0d_wdata", g), mwd, q[0].wd);
            chk($sformatf("L%0d_we_ready", g), ready, 1);
          end
          if (ready) begin
            e = q.pop_front();
            chk($sformatf("L%0d_latency", g), cyc, e.lat);
            chk($sformatf("L%0d_mem_we", g), nwe, e.nwe);
            chk($sformatf("L%0d_tmo", g), tflag, e.tmo);
            chk($sformatf("L%0d_maddr", g), maddr, e.a);
            if (e.chkd)
              chk($sformatf("L%0d_data", g), data_i, e.data);
            cyc = 0; nwe = 0;
          end else if (cyc > 64) begin
            chk($sformatf("L%0d_ready_bound", g), cyc, 0);
            void'(q.pop_front());
            cyc = 0; nwe = 0;
          end
        end
      end
    end

    // I/O responder: acks on the chosen IOREQ cycle, stray acks elsewhere.
    initial begin
      int k = 0;
      forever begin
        @(posedge clk);
        #1;
        if (ioreq) begin
          k++;
          if (k == 1) begin
            chk($sformatf("L%0d_io_addr", g), ioaddr, addr[7:0]);
            chk($sformatf("L%0d_io_we", g), iowe, we);
            chk($sformatf("L%0d_io_wdata", g), iowd, wd);
          end
          if (k == d_cur) begin
            ioack = 1'b1; iord = rd_cur;
          end else begin
            ioack = 1'b0; iord = 8'($urandom);
          end
        end else begin
          k = 0;
          ioack = ($urandom % 6) == 0;
          iord = 8'($urandom);
        end
      end
    end

    // Driver: reset, directed cases, random traffic, mid-access reset.
    initial begin
      addr = 16'hD055;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      chk($sformatf("L%0d_rst_ready", g), ready, 0);
      chk($sformatf("L%0d_rst_data", g), data_i, 0);
      chk($sformatf("L%0d_rst_req", g), ioreq, 0);
      chk($sformatf("L%0d_rst_tmo", g), tflag, 0);
      chk($sformatf("L%0d_rst_ioaddr", g), ioaddr, 0);
      chk($sformatf("L%0d_rst_iowe", g), iowe, 0);
      chk($sformatf("L%0d_rst_iowd", g), iowd, 0);
      rst_n = 1'b1;
      if (g == 0) begin
        run(16'h1234, 0, 8'h00, 8'hA5, 0, 8'h00, 0);
        run(16'h0200, 1, 8'h3C, 8'h00, 0, 8'h00, 0);
        run(16'hD012, 0, 8'h00, 8'h00, 3, 8'h5A, 0);
        run(16'hD0FF, 1, 8'h77, 8'h00, 99, 8'h00, 0);
        run(16'h0300, 0, 8'h00, 8'h11, 0, 8'h00, 0);
        run(16'hD0FF, 1, 8'h77, 8'h00, 99, 8'h00, 1);
        run(16'h0300, 0, 8'h00, 8'h22, 0, 8'h00, 1);
        run(16'hD040, 0, 8'h00, 8'h00, TMO, 8'hC3, 0);
      end else begin
        run(16'h8000, 0, 8'h00, 8'h6E, 0, 8'h00, 0);
        run(16'h8001, 1, 8'h9D, 8'h00, 0, 8'h00, 0);
        run(16'hD040, 0, 8'h00, 8'h00, TMO, 8'hC3, 0);
      end
      for (int i = 0; i < 150; i++) rnd_txn();
      run(16'hD0AA, 0, 8'h00, 8'h00, TMO + 5, 8'h00, 0);
      start(16'hD0BB, 0, 8'h00, 8'h00, TMO + 5, 8'h00, 0);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      @(posedge clk);
      #1;
      chk($sformatf("L%0d_mid_req", g), ioreq, 0);
      chk($sformatf("L%0d_mid_tmo", g), tflag, 0);
      chk($sformatf("L%0d_mid_ready", g), ready, 0);
      chk($sformatf("L%0d_mid_data", g), data_i, 0);
      q.delete();
      tmo_m = 1'b0;
      rst_n = 1'b1;
      start(16'h4321, 0, 8'h00, 8'hB7, 0, 8'h00, 0);
      wait_done();
      for (int i = 0; i < 20; i++) rnd_txn();
      addr = 16'h0000; we = 1'b0;
      done[g] = 1'b1;
    end
  end

  initial begin
    int n = 0;
    while (!(done[0] && done[1]) && n < 60000) begin
      @(posedge clk);
      n++;
    end
    if (!(done[0] && done[1])) begin
      checks++;
      failures++;
      $display("FAIL run_bound actual=%0d required=done", n);
    end
    repeat (2) @(posedge clk);
    $display("TB_RESULT checks=%0d failures=%0d",
             checks, failures);
    $finish;
  end

endmodule
